rx_ts_loader: RTL and testbench
===============================

RX_TS_LOADER -- requirements
Module: rx_ts_loader

Interface
REQ-001 SHALL have parameter MAGIC, default 16'hA55A: required header tag in word0[31:16].
REQ-002 SHALL have parameter MSG_TYPE, default 8'h01: the "set time" message code, in word0[15:8].
REQ-003 SHALL have parameter TIMEOUT, default 1024: maximum cycles from first word to rec_pkt_done.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rec_en, input, 1 bit: one-cycle strobe, one per received 32-bit payload word.
REQ-007 SHALL have port rec_data, input, 32 bits: payload word, valid when rec_en=1; first byte is in [31:24].
REQ-008 SHALL have port rec_pkt_done, input, 1 bit: one-cycle end-of-packet pulse; it may coincide with the last rec_en.
REQ-009 SHALL have port rec_byte_num, input, 16 bits: payload byte count, valid when rec_pkt_done=1.
REQ-010 SHALL have port ts_ack, input, 1 bit: acknowledge from the local time counter.
REQ-011 SHALL have port ts_load, output, 1 bit: load request, held high until ts_ack.
REQ-012 SHALL have port ts_sec, output, 48 bits: seconds value to load.
REQ-013 SHALL have port ts_nsec, output, 32 bits: nanoseconds value to load.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port pkt_cnt, output, 16 bits: count of accepted loads; wraps.
REQ-016 SHALL have port err_cnt, output, 8 bits: count of rejected packets; saturates at 255.

Function
REQ-017 SHALL use payload format: word0={MAGIC,type,seq[7:0]}; word1=sec[47:16]; word2={sec[15:0],nsec[31:16]}; word3={nsec[15:0],16'h0}.
REQ-018 SHALL implement states IDLE, W1, W2, W3, WAIT_DONE, CHECK, LOAD.
REQ-019 SHALL, in IDLE, on rec_en: capture word0 and go to W1; on rec_pkt_done with no rec_en: increment err_cnt and stay in IDLE.
REQ-020 SHALL, in W1/W2/W3, capture each word on rec_en and advance W1->W2->W3->WAIT_DONE.
REQ-021 SHALL, in WAIT_DONE, ignore extra rec_en words; on rec_pkt_done go to CHECK.
REQ-022 SHALL, when rec_pkt_done coincides with the word3 rec_en in W3, capture the word and go directly to CHECK.
REQ-023 SHALL, on rec_pkt_done in W1/W2/W3 without a completing word3, count a short-packet error and return to IDLE.
REQ-024 SHALL latch rec_byte_num on the rec_pkt_done cycle.
REQ-025 SHALL, in CHECK (one cycle), reject the packet if any holds: tag!=MAGIC, type!=MSG_TYPE, byte_num<14, nsec>=32'd1_000_000_000, or seq==last accepted seq while the last-seq-valid flag is set.
REQ-026 SHALL, on rejection: increment err_cnt (saturating) and go to IDLE; on acceptance: update ts_sec/ts_nsec, record seq, set the last-seq-valid flag, and go to LOAD.
REQ-027 SHALL assert ts_load on the cycle after CHECK; latency from rec_pkt_done to ts_load is 2 cycles.
REQ-028 SHALL hold ts_load=1 in LOAD until ts_ack=1; in the ack cycle it SHALL increment pkt_cnt, and ts_load SHALL be 0 on the next cycle, with the state back in IDLE.
REQ-029 SHALL, in LOAD, ignore rec_en and increment err_cnt once per rec_pkt_done (packet dropped).
REQ-030 SHALL hold ts_sec/ts_nsec stable except on acceptance in CHECK.
REQ-031 SHALL run a timeout counter from word0 capture; if the counter reaches TIMEOUT in W1..WAIT_DONE, it SHALL count an error and return to IDLE.
REQ-032 SHALL ignore ts_ack outside LOAD.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force: state=IDLE, ts_load=0, ts_sec=0, ts_nsec=0, busy=0, pkt_cnt=0, err_cnt=0, last-seq-valid flag=0, timeout counter=0.
REQ-034 SHALL, after reset is asserted mid-packet, discard all partial words; the first rec_en after release SHALL be treated as word0.

Verification
REQ-035 SHALL be verified with: words A55A0107, 00000000, 5F3E1234, 5678_0000, done with byte_num=16 -> ts_load 2 cycles after done, ts_sec=48'h0000_5F3E, ts_nsec=32'h1234_5678, and pkt_cnt=1 after ack.
REQ-036 SHALL be verified with: the same packet again with seq=07 -> no ts_load, err_cnt=1; then seq=08 -> accepted.
REQ-037 SHALL be verified with: nsec=3B9ACA00 (1e9) -> rejected, err_cnt increments; nsec=3B9AC9FF -> accepted.
REQ-038 SHALL be verified with: rec_pkt_done after 2 words -> short error, IDLE; then a 5-word packet with byte_num=20 -> accepted, extra word ignored.
REQ-039 SHALL be verified with: ts_ack held low 50 cycles while a second packet completes -> ts_load held, err_cnt+1, outputs unchanged until ack.
REQ-040 SHALL be verified with: word0 and no done for 1024 cycles -> error, IDLE; and rst_n pulsed low in W2 -> all outputs zero, next packet decoded normally.

Source files
------------

// File: rtl/rx_ts_loader.sv
// Receives a four-word "set time" payload, validates it and hands the decoded
// seconds/nanoseconds to the local time counter with a load/ack handshake.
module rx_ts_loader #(
  parameter logic [15:0] MAGIC    = 16'hA55A,
  parameter logic [7:0]  MSG_TYPE = 8'h01,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rec_en,
  input  logic [31:0] rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  input  logic        ts_ack,
  output logic        ts_load,
  output logic [47:0] ts_sec,
  output logic [31:0] ts_nsec,
  output logic        busy,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  err_cnt
);

  localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [31:0] NSEC_MAX  = 32'd1_000_000_000;
  localparam logic [15:0] MIN_BYTES = 16'd14;

  typedef enum logic [2:0] {
    S_IDLE, S_W1, S_W2, S_W3, S_WAIT_DONE, S_CHECK, S_LOAD
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        w0_q, w0_d;
  logic [31:0]        w1_q, w1_d;
  logic [31:0]        w2_q, w2_d;
  logic [15:0]        w3_q, w3_d;
  logic [15:0]        byte_num_q, byte_num_d;
  logic [47:0]        sec_q, sec_d;
  logic [31:0]        nsec_q, nsec_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic [7:0]         last_seq_q, last_seq_d;
  logic               seq_vld_q, seq_vld_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic               err_inc;
  logic               reject;
  logic               tmo_hit;
  logic [31:0]        nsec_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      w0_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      w3_q       <= '0;
      byte_num_q <= '0;
      sec_q      <= '0;
      nsec_q     <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      last_seq_q <= '0;
      seq_vld_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      w3_q       <= w3_d;
      byte_num_q <= byte_num_d;
      sec_q      <= sec_d;
      nsec_q     <= nsec_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      last_seq_q <= last_seq_d;
      seq_vld_q  <= seq_vld_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    w3_d       = w3_q;
    byte_num_d = rec_pkt_done ? rec_byte_num : byte_num_q;
    sec_d      = sec_q;
    nsec_d     = nsec_q;
    pkt_cnt_d  = pkt_cnt_q;
    last_seq_d = last_seq_q;
    seq_vld_d  = seq_vld_q;
    tmo_d      = tmo_q;
    err_inc    = 1'b0;

    nsec_rx = {w2_q[15:0], w3_q};
    reject  = (w0_q[31:16] != MAGIC) || (w0_q[15:8] != MSG_TYPE) ||
              (byte_num_q < MIN_BYTES) || (nsec_rx >= NSEC_MAX) ||
              (seq_vld_q && (w0_q[7:0] == last_seq_q));
    tmo_hit = (tmo_q >= TMO_W'(TIMEOUT - 1));

    if (state_q inside {S_W1, S_W2, S_W3, S_WAIT_DONE}) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    // End-of-packet wins over timeout, which wins over a new word
    unique case (state_q)
      S_IDLE: begin
        if (rec_en) begin
          w0_d  = rec_data;
          tmo_d = '0;
          if (rec_pkt_done) err_inc = 1'b1;
          else              state_d = S_W1;
        end else if (rec_pkt_done) begin
          err_inc = 1'b1;
        end
      end
      S_W1, S_W2: begin
        if (rec_pkt_done || tmo_hit) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else if (rec_en) begin
          if (state_q == S_W1) begin
            w1_d    = rec_data;
            state_d = S_W2;
          end else begin
            w2_d    = rec_data;
            state_d = S_W3;
          end
        end
      end
      S_W3: begin
        if (rec_en && rec_pkt_done) begin
          w3_d    = rec_data[31:16];
          state_d = S_CHECK;
        end else if (rec_pkt_done || tmo_hit) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else if (rec_en) begin
          w3_d    = rec_data[31:16];
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (rec_pkt_done) begin
          state_d = S_CHECK;
        end else if (tmo_hit) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (reject) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          sec_d      = {w1_q, w2_q[31:16]};
          nsec_d     = nsec_rx;
          last_seq_d = w0_q[7:0];
          seq_vld_d  = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rec_pkt_done) err_inc = 1'b1;
        if (ts_ack) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    load_d    = (state_d == S_LOAD);
    busy_d    = (state_d != S_IDLE);
  end

  assign ts_load = load_q;
  assign ts_sec  = sec_q;
  assign ts_nsec = nsec_q;
  assign busy    = busy_q;
  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_rx_ts_loader.sv
// Directed bench for rx_ts_loader: hand-computed packets, outputs sampled on the falling edge.
module tb_rx_ts_loader;

  logic        clk;
  logic        rst_n;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic        ts_ack;
  logic        ts_load;
  logic [47:0] ts_sec;
  logic [31:0] ts_nsec;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic [7:0]  err_cnt;

  int n_chk;
  int n_err;

  rx_ts_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num),
    .ts_ack       (ts_ack),
    .ts_load      (ts_load),
    .ts_sec       (ts_sec),
    .ts_nsec      (ts_nsec),
    .busy         (busy),
    .pkt_cnt      (pkt_cnt),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic word(input logic [31:0] d, input logic dn, input logic [15:0] bn);
    rec_en       = 1'b1;
    rec_data     = d;
    rec_pkt_done = dn;
    rec_byte_num = bn;
    @(negedge clk);
    rec_en       = 1'b0;
    rec_pkt_done = 1'b0;
  endtask

  task automatic pdone(input logic [15:0] bn);
    rec_pkt_done = 1'b1;
    rec_byte_num = bn;
    @(negedge clk);
    rec_pkt_done = 1'b0;
  endtask

  // Four words with end-of-packet on the last one
  task automatic pkt(input logic [31:0] w0, input logic [31:0] w1,
                     input logic [31:0] w2, input logic [31:0] w3);
    word(w0, 1'b0, 16'd0);
    word(w1, 1'b0, 16'd0);
    word(w2, 1'b0, 16'd0);
    word(w3, 1'b1, 16'd16);
  endtask

  task automatic ack();
    ts_ack = 1'b1;
    @(negedge clk);
    ts_ack = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    rec_en = 1'b0;
    rec_data = '0;
    rec_pkt_done = 1'b0;
    rec_byte_num = '0;
    ts_ack = 1'b0;

    cyc(2);
    chk("rst_load", 64'(ts_load), 64'd0);
    chk("rst_sec",  64'(ts_sec),  64'd0);
    chk("rst_nsec", 64'(ts_nsec), 64'd0);
    chk("rst_busy", 64'(busy),    64'd0);
    chk("rst_pkt",  64'(pkt_cnt), 64'd0);
    chk("rst_err",  64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    cyc(1);

    // Basic packet with a separate done pulse: load appears 2 cycles after done
    word(32'hA55A0107, 1'b0, 16'd0);
    chk("busy_w1", 64'(busy), 64'd1);
    word(32'h00000000, 1'b0, 16'd0);
    word(32'h5F3E1234, 1'b0, 16'd0);
    word(32'h56780000, 1'b0, 16'd0);
    pdone(16'd16);
    chk("lat1_load", 64'(ts_load), 64'd0);
    cyc(1);
    chk("lat2_load", 64'(ts_load), 64'd1);
    chk("p1_sec",  64'(ts_sec),  64'h0000_0000_5F3E);
    chk("p1_nsec", 64'(ts_nsec), 64'h1234_5678);
    cyc(3);
    chk("p1_hold", 64'(ts_load), 64'd1);
    ack();
    chk("p1_ack_load", 64'(ts_load), 64'd0);
    chk("p1_pkt",  64'(pkt_cnt), 64'd1);
    chk("p1_busy", 64'(busy),    64'd0);
    chk("p1_err",  64'(err_cnt), 64'd0);

    // Duplicate sequence number is rejected, next sequence accepted
    pkt(32'hA55A0107, 32'h00000000, 32'h5F3E1234, 32'h56780000);
    cyc(1);
    chk("dup_load", 64'(ts_load), 64'd0);
    chk("dup_err",  64'(err_cnt), 64'd1);
    chk("dup_sec",  64'(ts_sec),  64'h0000_0000_5F3E);
    pkt(32'hA55A0108, 32'h00000001, 32'h00021111, 32'h22220000);
    chk("s8_lat1", 64'(ts_load), 64'd0);
    cyc(1);
    chk("s8_load", 64'(ts_load), 64'd1);
    chk("s8_sec",  64'(ts_sec),  64'h0000_0001_0002);
    chk("s8_nsec", 64'(ts_nsec), 64'h1111_2222);
    ack();
    chk("s8_pkt", 64'(pkt_cnt), 64'd2);

    // Nanosecond boundary: 1e9 rejected, 1e9-1 accepted
    pkt(32'hA55A0109, 32'h00000000, 32'h00003B9A, 32'hCA000000);
    cyc(1);
    chk("ns1e9_load", 64'(ts_load), 64'd0);
    chk("ns1e9_err",  64'(err_cnt), 64'd2);
    chk("ns1e9_nsec", 64'(ts_nsec), 64'h1111_2222);
    pkt(32'hA55A010A, 32'h00000000, 32'h00003B9A, 32'hC9FF0000);
    cyc(1);
    chk("nsmax_load", 64'(ts_load), 64'd1);
    chk("nsmax_sec",  64'(ts_sec),  64'd0);
    chk("nsmax_nsec", 64'(ts_nsec), 64'h3B9A_C9FF);
    ack();
    chk("nsmax_pkt", 64'(pkt_cnt), 64'd3);

    // Short packet, then a five-word packet whose extra word is ignored
    word(32'hA55A010B, 1'b0, 16'd0);
    word(32'h00000000, 1'b0, 16'd0);
    pdone(16'd8);
    chk("short_err",  64'(err_cnt), 64'd3);
    chk("short_busy", 64'(busy),    64'd0);
    word(32'hA55A010C, 1'b0, 16'd0);
    word(32'hDEADBEEF, 1'b0, 16'd0);
    word(32'hCAFE0000, 1'b0, 16'd0);
    word(32'h00010000, 1'b0, 16'd0);
    word(32'hFFFFFFFF, 1'b0, 16'd0);
    pdone(16'd20);
    cyc(1);
    chk("w5_load", 64'(ts_load), 64'd1);
    chk("w5_sec",  64'(ts_sec),  64'hDEAD_BEEF_CAFE);
    chk("w5_nsec", 64'(ts_nsec), 64'h0000_0001);
    ack();
    chk("w5_pkt", 64'(pkt_cnt), 64'd4);

    // Slow ack: a packet arriving during LOAD is dropped and counted
    pkt(32'hA55A010D, 32'h00000002, 32'h00030000, 32'h00050000);
    cyc(1);
    chk("slow_load0", 64'(ts_load), 64'd1);
    pkt(32'hA55A010E, 32'h11111111, 32'h22220000, 32'h33330000);
    cyc(46);
    chk("slow_load", 64'(ts_load), 64'd1);
    chk("slow_err",  64'(err_cnt), 64'd4);
    chk("slow_sec",  64'(ts_sec),  64'h0000_0002_0003);
    chk("slow_nsec", 64'(ts_nsec), 64'h0000_0005);
    chk("slow_pkt",  64'(pkt_cnt), 64'd4);
    ack();
    chk("slow_ack_load", 64'(ts_load), 64'd0);
    chk("slow_ack_pkt",  64'(pkt_cnt), 64'd5);
    chk("slow_ack_busy", 64'(busy),    64'd0);

    // Stray done in IDLE
    pdone(16'd16);
    chk("stray_err", 64'(err_cnt), 64'd5);

    // Timeout after word0 with no further activity
    word(32'hA55A010F, 1'b0, 16'd0);
    cyc(1000);
    chk("tmo_busy_pre", 64'(busy),    64'd1);
    chk("tmo_err_pre",  64'(err_cnt), 64'd5);
    cyc(30);
    chk("tmo_busy", 64'(busy),    64'd0);
    chk("tmo_err",  64'(err_cnt), 64'd6);

    // Reset in W2 clears everything; next packet decodes normally
    word(32'hA55A0110, 1'b0, 16'd0);
    word(32'h00000000, 1'b0, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst_sec",  64'(ts_sec),  64'd0);
    chk("mrst_nsec", 64'(ts_nsec), 64'd0);
    chk("mrst_busy", 64'(busy),    64'd0);
    chk("mrst_pkt",  64'(pkt_cnt), 64'd0);
    chk("mrst_err",  64'(err_cnt), 64'd0);
    chk("mrst_load", 64'(ts_load), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    pkt(32'hA55A0107, 32'h00000000, 32'h5F3E1234, 32'h56780000);
    cyc(1);
    chk("post_load", 64'(ts_load), 64'd1);
    chk("post_sec",  64'(ts_sec),  64'h0000_0000_5F3E);
    chk("post_nsec", 64'(ts_nsec), 64'h1234_5678);
    chk("post_err",  64'(err_cnt), 64'd0);
    ack();
    chk("post_pkt", 64'(pkt_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
